// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
// Word-addressed data memory with per-byte write enables and in-order responses via a small FIFO.
// Latency: 2 edges from accept to rsp_valid when the FIFO is empty; 1 accept/cycle with RSP_DEPTH=3.
// Backpressure: req_ready drops once FIFO entries plus the in-flight S1 access reach RSP_DEPTH.
module dmem_responder #(
    parameter int DEPTH      = 4096,
    parameter int DATA_WIDTH = 32,
    parameter int RSP_DEPTH  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [31:0]               req_addr,
    input  logic [DATA_WIDTH/8-1:0]   req_wen,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int DATA_BYTES = DATA_WIDTH / 8;
    localparam int FIFO_N     = RSP_DEPTH - 1;
    localparam int PTR_W      = (FIFO_N > 1) ? $clog2(FIFO_N) : 1;
    localparam int CNT_W      = $clog2(RSP_DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FIFO_N - 1);
    localparam logic [CNT_W-1:0] CNT_FIFO_N = CNT_W'(FIFO_N);
    localparam logic [CNT_W-1:0] CNT_RSP    = CNT_W'(RSP_DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  s1_valid;
    logic [ADDR_WIDTH-1:0] s1_idx;
    logic                  s1_err;

    logic [DATA_WIDTH-1:0] fifo_rdata [FIFO_N];
    logic                  fifo_err   [FIFO_N];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      fifo_count;

    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  req_oor;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [CNT_W-1:0]      occupancy;
    logic [DATA_WIDTH-1:0] s1_rdata;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^req_addr[1:0];
    assign req_idx   = req_addr[ADDR_WIDTH+1:2];
    assign req_oor   = |req_addr[31:ADDR_WIDTH+2];

    // Ready depends only on registered occupancy so no path exists from rsp_ready/req_valid.
    assign occupancy = fifo_count + CNT_W'(s1_valid);
    assign req_ready = (occupancy < CNT_RSP);
    assign accept    = req_valid && req_ready && !rst;

    assign rsp_valid = (fifo_count != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign push      = s1_valid && ((fifo_count < CNT_FIFO_N) || pop);

    // Read happens one cycle after the write edge, so S1 always sees the merged word.
    assign s1_rdata  = s1_err ? '0 : mem[s1_idx];

    assign rsp_rdata = rsp_valid ? fifo_rdata[rd_ptr] : '0;
    assign rsp_err   = rsp_valid && fifo_err[rd_ptr];

    always_ff @(posedge clk) begin
        if (accept && !req_oor) begin
            for (int b = 0; b < DATA_BYTES; b++) begin
                if (req_wen[b]) begin
                    mem[req_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rdata[wr_ptr] <= s1_rdata;
            fifo_err[wr_ptr]   <= s1_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_idx     <= '0;
            s1_err     <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_idx   <= req_idx;
                s1_err   <= req_oor;
            end else if (push) begin
                s1_valid <= 1'b0;
            end
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for dmem_responder: a reference word model predicts each response at accept time.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [3:0]  req_wen = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(4096), .DATA_WIDTH(32), .RSP_DEPTH(3)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    typedef struct packed { logic err; logic [31:0] dat; } rsp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_acc = 0;
    int          n_pop = 0;
    int          dropped = 0;
    rsp_t        sb[$];
    rsp_t        obs[$];
    logic [31:0] mdl [4096];
    logic        track = 1'b0;
    int          first_acc = -1;
    int          last_acc = -1;
    int          first_vld = -1;
    logic        hold_vld = 1'b0;
    rsp_t        hold_val;
    rsp_t        got;
    rsp_t        want;
    logic        rnd_done = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs_v, input logic [63:0] exp_v);
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs_v, exp_v);
        end
    endtask

    function automatic rsp_t model_apply(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        rsp_t r;
        if (a[31:14] != '0) begin
            r = {1'b1, 32'h0};
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (w[b]) mdl[a[13:2]][8*b +: 8] = d[8*b +: 8];
            end
            r = {1'b0, mdl[a[13:2]]};
        end
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Inputs only change just after posedge, so the negedge view predicts the next edge exactly.
    always @(negedge clk) begin
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            got = {rsp_err, rsp_rdata};
            if (rsp_valid && hold_vld) check("hold", got, hold_val);
            hold_vld = rsp_valid && !rsp_ready;
            hold_val = got;
            if (rsp_valid && track && first_vld < 0) first_vld = cyc;
            if (rsp_valid && rsp_ready) begin
                n_pop++;
                obs.push_back(got);
                if (sb.size() == 0) begin
                    check("extra_rsp", 1, 0);
                end else begin
                    want = sb.pop_front();
                    check("rsp", got, want);
                end
            end
            if (req_valid && req_ready) begin
                n_acc++;
                sb.push_back(model_apply(req_addr, req_wen, req_wdata));
                if (track) begin
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        bit acc = 1'b0;
        req_valid = 1'b1;
        req_addr  = a;
        req_wen   = w;
        req_wdata = d;
        for (int i = 0; i < 500 && !acc; i++) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("req_timeout", 0, 1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2000 && sb.size() != 0; i++) tick(1);
        check("drain", sb.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w0;
        int np0;

        rst = 1'b1;
        tick(3);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        rst = 1'b0;
        tick(1);

        for (int i = 0; i < 32; i++) send(32'(i) << 2, 4'hF, $urandom);
        drain();

        obs.delete();
        send(32'h100, 4'hF, 32'h11223344);
        send(32'h100, 4'b0101, 32'hAABBCCDD);
        send(32'h100, 4'h0, 32'h0);
        drain();
        check("merge_cnt", obs.size(), 3);
        if (obs.size() == 3) begin
            check("merge0", obs[0], {1'b0, 32'h11223344});
            check("merge1", obs[1], {1'b0, 32'h11BB33DD});
            check("merge2", obs[2], {1'b0, 32'h11BB33DD});
        end

        obs.delete();
        w0 = mdl[0];
        send(32'h0000_4000, 4'hF, 32'hDEADBEEF);
        send(32'h0, 4'h0, 32'h0);
        drain();
        check("oor_cnt", obs.size(), 2);
        if (obs.size() == 2) begin
            check("oor_err", obs[0], {1'b1, 32'h0});
            check("oor_word0", obs[1], {1'b0, w0});
        end

        rsp_ready = 1'b0;
        send(32'h0, 4'h0, 32'h0);
        send(32'h4, 4'h0, 32'h0);
        tick(2);
        check("q2_valid", rsp_valid, 1);
        np0 = n_pop;
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", rsp_valid, 0);
        check("midrst_ready", req_ready, 1);
        dropped += sb.size();
        sb.delete();
        tick(2);
        rst = 1'b0;
        rsp_ready = 1'b1;
        tick(6);
        check("no_stale_valid", rsp_valid, 0);
        check("no_stale_pop", n_pop, np0);

        obs.delete();
        rsp_ready = 1'b0;
        np0 = n_acc;
        for (int i = 0; i < 3; i++) send(32'(i) << 2, 4'h0, 32'h0);
        @(negedge clk);
        check("bp_ready_low", req_ready, 0);
        check("bp_accepts", n_acc - np0, 3);
        @(posedge clk);
        #1;
        fork
            begin
                send(32'hC, 4'h0, 32'h0);
                send(32'h10, 4'h0, 32'h0);
            end
            begin
                tick(3);
                rsp_ready = 1'b1;
            end
        join
        drain();
        check("bp_cnt", obs.size(), 5);
        if (obs.size() == 5) begin
            for (int i = 0; i < 5; i++) check("bp_data", obs[i], {1'b0, mdl[i]});
        end

        obs.delete();
        fork
            begin
                for (int i = 0; i < 20; i++) send(32'(i % 32) << 2, 4'h0, 32'h0);
            end
            begin
                for (int j = 0; j < 40; j++) begin
                    rsp_ready = (j % 4) != 0;
                    tick(1);
                end
                rsp_ready = 1'b1;
            end
        join
        drain();
        check("wrap_cnt", obs.size(), 20);

        rsp_ready = 1'b1;
        track = 1'b1;
        for (int i = 0; i < 16; i++) send(32'(40 + i) << 2, 4'hF, $urandom);
        for (int i = 0; i < 16; i++) send(32'(40 + i) << 2, 4'h0, 32'h0);
        drain();
        track = 1'b0;
        check("stream_span", last_acc - first_acc, 31);
        check("stream_latency", first_vld - first_acc, 2);

        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    logic [31:0] a;
                    logic [3:0]  w;
                    if ($urandom_range(0, 3) == 0) tick(1);
                    if ($urandom_range(0, 19) == 0) a = $urandom | 32'h0000_4000;
                    else a = {25'h0, 5'($urandom_range(0, 31)), 2'($urandom)};
                    w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                    send(a, w, $urandom);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    rsp_ready = ($urandom_range(0, 3) != 0);
                    tick(1);
                end
                rsp_ready = 1'b1;
            end
        join
        drain();

        check("acc_vs_pop", n_pop + dropped, n_acc);
        check("dropped_cnt", dropped, 2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
